cacheline_adaptor_p: RTL and testbench
======================================

Name: cacheline_adaptor_p

Overview:
- Sits directly downstream of the pipelined cache datapath, between its memory-side port and physical memory.
- Converts one 256-bit cacheline transfer into a 4-beat burst of 64-bit words, in both directions.
- Line fills go memory -> cache. Writebacks go cache -> memory.
- Signals completion to the cache controller with a single-cycle response pulse.

Parameters:
- s_line, 256, cacheline width in bits.
- s_beat, 64, burst beat width in bits.
- n_beats, 4, beats per line (= s_line/s_beat).
- s_offset, 5, line offset bits zeroed in the memory address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- line_i  input  256  cacheline to write back (cache cacheline_data_out).
- line_o  output  256  assembled fill line (cache data_from_mem).
- address_i  input  32  line address from cache (address_to_mem).
- read_i  input  1  cache requests line fill.
- write_i  input  1  cache requests writeback.
- resp_o  output  1  one-cycle completion pulse to cache.
- burst_i  input  64  read beat from memory.
- burst_o  output  64  write beat to memory.
- address_o  output  32  aligned burst address to memory.
- read_o  output  1  memory read request.
- write_o  output  1  memory write request.
- resp_i  input  1  memory beat-valid/accept strobe.

Behaviour:
- States: IDLE, RD, RD_DONE, WR, WR_DONE. A 2-bit beat counter cnt wraps 3->0.
- Reset (rst=0, async):
  - state=IDLE, cnt=0.
  - line_o=0, burst_o=0, address_o=0.
  - read_o=0, write_o=0, resp_o=0.
- IDLE:
  - If read_i=1: latch {address_i[31:5],5'b0} into address_o, cnt=0, go to RD.
  - Else if write_i=1: latch the same address, latch line_i into an internal buffer, cnt=0, go to WR.
  - read_i has priority when both are high. The write is then not accepted; the cache re-presents it later.
  - resp_i in IDLE is ignored.
- RD:
  - read_o=1 for the entire state. address_o is stable.
  - Each cycle with resp_i=1: line_o[64*cnt +: 64] <= burst_i, cnt++.
  - resp_i=0 stalls the burst; no capture, cnt holds.
  - On the capture with cnt==3, go to RD_DONE.
- RD_DONE:
  - read_o=0, resp_o=1 for exactly one cycle, line_o holds the complete line, then IDLE.
- WR:
  - write_o=1 for the entire state.
  - burst_o = buffer[64*cnt +: 64], combinational from cnt, valid from the first WR cycle.
  - Each cycle with resp_i=1 the beat is accepted and cnt++.
  - On the accept with cnt==3, go to WR_DONE.
- WR_DONE:
  - write_o=0, resp_o=1 for one cycle, then IDLE.
- Latency: with resp_i high every cycle, a read takes 6 cycles from request sample to resp_o: accept, 4 beats, done. A write takes the same.
- line_o holds the last fill until the next fill overwrites it beat by beat. It is not cleared on write.
- Requests are level-sensitive. The cache must drop read_i/write_i on the edge where it samples resp_o, so IDLE does not re-accept.
- read_i/write_i changes while in RD/WR/DONE are ignored. address_i and line_i are sampled only at accept.
- read_o and write_o are never high simultaneously. resp_o is never high outside the DONE states.
- Reset mid-burst: abort immediately, read_o/write_o drop asynchronously, partial line_o is cleared to 0, and no resp_o is issued.

Test Plan:
- Reset then idle: rst=0 for 2 cycles -> all outputs 0; resp_i pulses in IDLE -> no state change, resp_o=0.
- Line fill: address_i=0x0000_1234, read_i=1; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> address_o=0x0000_1220, read_o high for 4 cycles, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o pulses once on cycle 6.
- Writeback with stall: line_i=256'hDDDD..CCCC..BBBB..AAAA (beats A,B,C,D), write_i=1; resp_i pattern 1,0,0,1,1,1 -> burst_o shows A,B,B,B,C,D; write_o deasserts after D; resp_o pulses once.
- Simultaneous read_i=1, write_i=1 in IDLE -> RD taken, write_o stays 0 throughout.
- Reset after 2 read beats -> read_o falls without a clock edge, line_o=0, no resp_o; a subsequent read completes normally.
- Back-to-back: read done, cache raises write_i the cycle after resp_o -> write accepted, no spurious second read.

Source files
------------

// File: rtl/cacheline_adaptor_p.sv
// ============================================================================
// cacheline_adaptor_p
// ----------------------------------------------------------------------------
// Bridges the cache's memory-side port to a burst memory.
//   - Line fill:  a 256-bit line is collected from four 64-bit beats.
//   - Writeback:  a 256-bit line is sent out as four 64-bit beats.
// After the last beat, resp_o pulses for one cycle to tell the cache
// controller that the transfer is complete.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   line_i     line to write back (sampled when the write is accepted)
//   line_o     assembled fill line (held until the next fill)
//   address_i  line address from the cache (sampled on accept)
//   read_i     cache requests a line fill (level)
//   write_i    cache requests a writeback (level; read_i wins a tie)
//   resp_o     one-cycle completion pulse to the cache
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  line-aligned burst address to memory
//   read_o     memory read request, high for the whole RD state
//   write_o    memory write request, high for the whole WR state
//   resp_i     memory beat valid (read) / beat accepted (write)
// ============================================================================
module cacheline_adaptor_p #(
    parameter int s_line   = 256,
    parameter int s_beat   = 64,
    parameter int n_beats  = 4,
    parameter int s_offset = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [s_beat-1:0] burst_i,
    output logic [s_beat-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int cnt_w = $clog2(n_beats);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(n_beats - 1);
    // Mask that clears the offset bits inside the line.
    localparam logic [31:0] off_mask = (32'd1 << s_offset) - 32'd1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_DONE = 3'd2,
        WR      = 3'd3,
        WR_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [cnt_w-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [s_line-1:0]  line_q, line_d;
    logic [s_line-1:0]  buf_q, buf_d;

    // Per-beat views of the writeback buffer and per-beat capture enables
    // for the fill line.
    logic [s_beat-1:0]  buf_beat [n_beats];
    logic               cap_en   [n_beats];

    genvar gi;
    generate
        for (gi = 0; gi < n_beats; gi++) begin : g_beat
            assign buf_beat[gi] = buf_q[gi*s_beat +: s_beat];
            assign cap_en[gi]   = (state_q == RD) && resp_i && (cnt_q == cnt_w'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register and datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            buf_q   <= buf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                // resp_i is deliberately ignored here.
                if (read_i) begin
                    addr_d  = address_i & ~off_mask;
                    cnt_d   = '0;
                    state_d = RD;
                end else if (write_i) begin
                    addr_d  = address_i & ~off_mask;
                    buf_d   = line_i;
                    cnt_d   = '0;
                    state_d = WR;
                end
            end
            RD: begin
                if (resp_i) begin
                    cnt_d = cnt_q + cnt_w'(1);
                    if (cnt_q == last_beat) begin
                        state_d = RD_DONE;
                    end
                end
            end
            WR: begin
                if (resp_i) begin
                    cnt_d = cnt_q + cnt_w'(1);
                    if (cnt_q == last_beat) begin
                        state_d = WR_DONE;
                    end
                end
            end
            RD_DONE: state_d = IDLE;
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fill line: only the beat addressed by cnt is overwritten; the rest
    // keep their previous contents so line_o survives writebacks.
    always_comb begin
        line_d = line_q;
        for (int i = 0; i < n_beats; i++) begin
            if (cap_en[i]) begin
                line_d[i*s_beat +: s_beat] = burst_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state so reset drops them at once)
    // ------------------------------------------------------------------
    always_comb begin
        read_o    = (state_q == RD);
        write_o   = (state_q == WR);
        resp_o    = (state_q == RD_DONE) || (state_q == WR_DONE);
        burst_o   = (state_q == WR) ? buf_beat[cnt_q] : '0;
        address_o = addr_q;
        line_o    = line_q;
    end

endmodule

// File: tb/tb_cacheline_adaptor_p.sv
// ============================================================================
// tb_cacheline_adaptor_p
// Directed stimulus for cacheline_adaptor_p. Expected completions and write
// beats are queued when a request is driven and checked when the DUT
// produces them; direct checks cover reset, latency and protocol rules.
// ============================================================================
module tb_cacheline_adaptor_p;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    cacheline_adaptor_p dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         is_rd;
        logic [255:0] line;
    } resp_t;

    resp_t       resp_q [$];
    logic [63:0] beat_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for the cycle about to end, then advance one clock.
    task automatic cyc();
        resp_t e;
        chk("rd_wr_exclusive", {255'd0, read_o & write_o}, 256'd0);
        if (write_o && resp_i) begin
            chk("wr_beat_expected", {255'd0, beat_q.size() != 0}, 256'd1);
            if (beat_q.size() != 0) chk("wr_beat", {192'd0, burst_o}, {192'd0, beat_q.pop_front()});
        end
        if (resp_o) begin
            chk("resp_expected", {255'd0, resp_q.size() != 0}, 256'd1);
            if (resp_q.size() != 0) begin
                e = resp_q.pop_front();
                if (e.is_rd) chk("fill_line", line_o, e.line);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Line fill with resp_i high every beat. keep holds read_i until the
    // edge that samples resp_o; both also raises write_i alongside read_i.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input bit keep, input bit both);
        read_i    = 1'b1;
        write_i   = both;
        address_i = addr;
        cyc();
        $display("txn read  addr=%08h line=%064h", addr, line);
        chk("rd_addr", {224'd0, address_o}, {224'd0, addr & 32'hFFFF_FFE0});
        resp_q.push_back('{is_rd: 1'b1, line: line});
        if (!keep) begin
            read_i  = 1'b0;
            write_i = 1'b0;
        end
        address_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            burst_i = line[64*i +: 64];
            resp_i  = 1'b1;
            chk("rd_read_o", {255'd0, read_o}, 256'd1);
            chk("rd_write_o", {255'd0, write_o}, 256'd0);
            chk("rd_no_early_resp", {255'd0, resp_o}, 256'd0);
            cyc();
        end
        resp_i  = 1'b0;
        burst_i = '0;
        chk("rd_done_resp", {255'd0, resp_o}, 256'd1);
        chk("rd_done_read_o", {255'd0, read_o}, 256'd0);
        chk("rd_done_write_o", {255'd0, write_o}, 256'd0);
        cyc();
        read_i  = 1'b0;
        write_i = 1'b0;
        chk("rd_resp_single", {255'd0, resp_o}, 256'd0);
        chk("rd_addr_hold", {224'd0, address_o}, {224'd0, addr & 32'hFFFF_FFE0});
    endtask

    // Writeback; pat[0..n-1] is the resp_i pattern and must hold four ones.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int n, input logic [7:0] pat,
                            input logic [255:0] fill_hold);
        int k;
        write_i   = 1'b1;
        address_i = addr;
        line_i    = line;
        cyc();
        $display("txn write addr=%08h line=%064h", addr, line);
        chk("wr_addr", {224'd0, address_o}, {224'd0, addr & 32'hFFFF_FFE0});
        resp_q.push_back('{is_rd: 1'b0, line: line});
        for (int i = 0; i < 4; i++) beat_q.push_back(line[64*i +: 64]);
        write_i = 1'b0;
        line_i  = ~line;
        k = 0;
        for (int j = 0; j < n; j++) begin
            resp_i = pat[j];
            chk("wr_burst_o", {192'd0, burst_o}, {192'd0, line[64*k +: 64]});
            chk("wr_write_o", {255'd0, write_o}, 256'd1);
            chk("wr_read_o", {255'd0, read_o}, 256'd0);
            chk("wr_no_early_resp", {255'd0, resp_o}, 256'd0);
            cyc();
            if (pat[j]) k++;
        end
        resp_i = 1'b0;
        chk("wr_done_resp", {255'd0, resp_o}, 256'd1);
        chk("wr_done_write_o", {255'd0, write_o}, 256'd0);
        chk("wr_line_o_kept", line_o, fill_hold);
        cyc();
        chk("wr_resp_single", {255'd0, resp_o}, 256'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [255:0] fill1, fill2, fill3, fill4, wb1, wb2;

    initial begin
        fill1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        wb1   = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        fill2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5A5A_A5A5_0F0F_F0F0, 64'h8000_0000_0000_0001};
        fill3 = {64'hCAFE_0003_0000_0003, 64'hCAFE_0002_0000_0002,
                 64'hCAFE_0001_0000_0001, 64'hCAFE_0000_0000_0000};
        fill4 = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                 64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
        wb2   = {64'h7777_0000_0000_0004, 64'h6666_0000_0000_0003,
                 64'h5555_0000_0000_0002, 64'h4444_0000_0000_0001};

        // Reset
        rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0;
        write_i = 1'b0; burst_i = '0; resp_i = 1'b0;
        #1;
        chk("rst_async_outs", {line_o, burst_o, address_o, read_o, write_o, resp_o} != '0 ? 256'd1 : 256'd0, 256'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_line_o", line_o, 256'd0);
        chk("rst_burst_o", {192'd0, burst_o}, 256'd0);
        chk("rst_address_o", {224'd0, address_o}, 256'd0);
        chk("rst_ctrl", {253'd0, read_o, write_o, resp_o}, 256'd0);
        rst = 1'b1;
        $display("txn reset released");

        // resp_i in IDLE is ignored
        resp_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("idle_resp_i_ignored", {253'd0, read_o, write_o, resp_o}, 256'd0);
        end
        resp_i = 1'b0;
        cyc();

        // Line fill
        do_read(32'h0000_1234, fill1, 1'b0, 1'b0);
        chk("fill_line_held", line_o, fill1);

        // Writeback with stalls: resp_i 1,0,0,1,1,1
        do_write(32'h0000_5678, wb1, 6, 8'b0011_1001, fill1);

        // Read and write together: read wins
        do_read(32'hABCD_EF7F, fill2, 1'b1, 1'b1);
        chk("tie_write_not_taken", {253'd0, read_o, write_o, resp_o}, 256'd0);
        cyc();
        chk("tie_idle_after", {253'd0, read_o, write_o, resp_o}, 256'd0);

        // Reset after two read beats
        read_i = 1'b1; address_i = 32'h0000_8040;
        cyc();
        $display("txn read  addr=%08h aborted by reset", 32'h0000_8040);
        read_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            burst_i = fill3[64*i +: 64];
            resp_i  = 1'b1;
            cyc();
        end
        chk("abort_read_o_before", {255'd0, read_o}, 256'd1);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_read_o_async", {255'd0, read_o}, 256'd0);
        chk("abort_line_o_clear", line_o, 256'd0);
        chk("abort_resp_o", {255'd0, resp_o}, 256'd0);
        resp_q.delete();
        beat_q.delete();
        resp_i = 1'b0; burst_i = '0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("abort_no_resp", {253'd0, read_o, write_o, resp_o}, 256'd0);
        do_read(32'h0000_8040, fill3, 1'b0, 1'b0);

        // Back-to-back: read held until resp_o sampled, then write next cycle
        do_read(32'h1000_0021, fill4, 1'b1, 1'b0);
        do_write(32'h2000_003F, wb2, 4, 8'b0000_1111, fill4);
        cyc();
        chk("b2b_no_second_read", {253'd0, read_o, write_o, resp_o}, 256'd0);
        chk("scoreboard_drained", {224'd0, 32'(resp_q.size() + beat_q.size())}, 256'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
